div_unit: RTL
=============

# div_unit

Iterative 32-bit divider for the MIPS-style execute stage. It produces the HI/LO write (quotient to LO, remainder to HI) for DIV/DIVU and drives the HI/LO register's write-enable and data inputs. The pipeline is held via `busy_o` while a division runs. One radix-2 restoring iteration completes per clock.

## Interface
- `DATA_W`, default 32: operand, quotient and remainder width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request a division; sampled only in IDLE.
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start_i`.
- `annul_i`  in  1  flush (exception or branch squash); aborts any in-flight division.
- `opdata1_i`  in  DATA_W  dividend; sampled with `start_i`.
- `opdata2_i`  in  DATA_W  divisor; sampled with `start_i`.
- `busy_o`  out  1  stall request to the pipeline control.
- `we_o`  out  1  one-cycle HI/LO write strobe.
- `hi_o`  out  DATA_W  remainder.
- `lo_o`  out  DATA_W  quotient.
- `dbz_o`  out  1  divide-by-zero flag; valid with `we_o`.

## Operation
- States:
  - IDLE: waits for `start_i`.
  - ON: 32 iteration cycles.
  - END: presents the result.
- IDLE transitions:
  - IDLE + `start_i` + !`annul_i` + divisor == 0 → END, with `lo_o`=all-ones, `hi_o`=dividend (raw, unmodified), `dbz_o`=1.
  - IDLE + `start_i` + !`annul_i` + divisor != 0 → ON. Latch operand magnitudes (abs value when signed), result signs and a 6-bit counter = 0.
- ON behaviour:
  - Datapath: a (2·DATA_W+1)-bit shift register {partial remainder, dividend/quotient}.
  - Each cycle: shift left 1, then trial-subtract the divisor from the upper DATA_W+1 bits.
  - Non-negative difference: replace the upper bits and set quotient LSB=1; otherwise set LSB=0.
  - Counter increments each cycle; counter == 31 at the edge → END.
- Sign fix-up on entering END:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) yields `lo_o`=0x80000000 and `hi_o`=0 through magnitude arithmetic, with no special case.
- END: `we_o`=1 for exactly one cycle, then → IDLE.
- `annul_i`=1 in any state → IDLE at the next edge. `we_o` is never asserted for an annulled division, including when `annul_i` arrives in END: `we_o` is gated by !`annul_i`.
- `start_i` outside IDLE is ignored. `start_i` and `annul_i` together in IDLE: the start is ignored.
- `hi_o`/`lo_o`/`dbz_o` are registered and hold their last result after END. The consumer uses them only when `we_o`=1.

## Timing
- Reset (asynchronous, `rst`=0): state=IDLE, `busy_o`=0, `we_o`=0, `hi_o`=0, `lo_o`=0, `dbz_o`=0, counter=0.
- Start sampled at edge T (cycle 0 = cycle in which `start_i` is high):
  - Normal divide: ON for cycles T+1…T+32; END (`we_o`=1) in cycle T+33; IDLE at T+34. Latency is 33 cycles.
  - Divide by zero: END in cycle T+1.
- `busy_o` = (state != IDLE) || (`start_i` && !`annul_i`). The issuing instruction therefore stalls in cycle T, and the stall continues through END.
- `busy_o` drops in the cycle after END. A new `start_i` can be accepted in that same cycle (T+34): back-to-back divides run every 34 cycles.
- `annul_i` in cycle N (N in ON) → IDLE in N+1, `busy_o`=0 in N+1 (unless `start_i` is asserted in N+1).

## Configuration
- `DIV_SIGNED_EN` defined: signed division as described.
- Not defined:
  - `signed_i` is ignored and every division is unsigned.
  - The abs-value and sign-fix-up logic is removed.
  - Divide-by-zero behaviour is unchanged.

## Structure
- Shared package `div_pkg` holds:
  - state enum `div_state_t` {IDLE, ON, END};
  - `DIV_CYCLES` = 32;
  - the divide-by-zero quotient constant (all-ones).
- One natural sub-module: `div_step`, a combinational single restoring iteration. Inputs: the shift register and the divisor. Outputs: the next shift register. It is instantiated once inside `div_unit`.

## Test plan
- Unsigned 100 / 7, start at T → `we_o` only in T+33, `lo_o`=14, `hi_o`=2, `dbz_o`=0, `busy_o` high T…T+33.
- Signed 0xFFFFFFF9 (-7) / 2 → `lo_o`=0xFFFFFFFD (-3), `hi_o`=0xFFFFFFFF (-1). Same operands with `signed_i`=0 → `lo_o`=0x7FFFFFFC, `hi_o`=1.
- Divide by zero: 5 / 0 → `we_o` in T+1, `lo_o`=0xFFFFFFFF, `hi_o`=5, `dbz_o`=1.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0.
- Flush handling:
  - `annul_i` at T+10 → no `we_o`, `busy_o`=0 at T+11; a new start at T+11 completes with `we_o` at T+44.
  - `annul_i` during END → no `we_o`.
- Reset deasserted-then-asserted (`rst`=0) at T+20 → all outputs 0 immediately. After release, `start_i` is accepted and the correct result follows.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
package div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE,
    ON,
    END
  } div_state_t;

  // Operand width the constants below are sized for
  localparam int DIV_DATA_W = 32;

  // One restoring iteration per quotient bit
  localparam int DIV_CYCLES = 32;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_DATA_W-1:0] DIV_DBZ_QUOT = {DIV_DATA_W{1'b1}};

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the execute stage and the divider.
// The pipeline side uses the master modport, the divider the slave modport.
interface div_unit_if #(
  parameter int DATA_W = 32
);

  logic              start_i;
  logic              signed_i;
  logic              annul_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              busy_o;
  logic              we_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              dbz_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  busy_o, we_o, hi_o, lo_o, dbz_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output busy_o, we_o, hi_o, lo_o, dbz_o
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// The shift register holds {partial remainder (DATA_W+1 bits), dividend/quotient}.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] sreg,
  input  logic [DATA_W-1:0] divisor,
  output logic [2*DATA_W:0] sreg_next
);

  logic [2*DATA_W:0] shifted;
  logic [DATA_W:0]   diff;

  // Shift left, trial-subtract the divisor, keep the difference only if it is non-negative
  always_comb begin
    shifted = {sreg[2*DATA_W-1:0], 1'b0};
    diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
    if (!diff[DATA_W]) begin
      sreg_next = {diff, shifted[DATA_W-1:1], 1'b1};
    end else begin
      sreg_next = shifted;
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU unit for the execute stage; quotient to LO,
// remainder to HI, stalls the pipeline through busy_o while it runs.
// Optional feature: define DIV_SIGNED_EN to honour signed_i (signed DIV);
// without it every division is unsigned and signed_i is ignored.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

  div_state_t        state;
  div_state_t        state_next;
  logic [5:0]        cnt;
  logic [2*DATA_W:0] sreg;
  logic [2*DATA_W:0] sreg_next;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              dbz_q;
  logic              accept;
  logic              busy;
  logic              we;
  logic [DATA_W-1:0] dividend_mag;
  logic [DATA_W-1:0] divisor_mag;
  logic [DATA_W-1:0] quot_final;
  logic [DATA_W-1:0] rem_final;

  // A start only counts when it is not being flushed in the same cycle
  assign accept = bus.start_i && !bus.annul_i;

`ifdef DIV_SIGNED_EN
  logic dividend_neg;
  logic divisor_neg;
  logic neg_quot;
  logic neg_rem;

  assign dividend_neg = bus.signed_i && bus.opdata1_i[DATA_W-1];
  assign divisor_neg  = bus.signed_i && bus.opdata2_i[DATA_W-1];
  assign dividend_mag = dividend_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign divisor_mag  = divisor_neg ? -bus.opdata2_i : bus.opdata2_i;
  assign quot_final   = neg_quot ? -sreg_next[DATA_W-1:0] : sreg_next[DATA_W-1:0];
  assign rem_final    = neg_rem ? -sreg_next[2*DATA_W-1:DATA_W] : sreg_next[2*DATA_W-1:DATA_W];

  // Remember the result signs when a division is accepted; the iteration itself is unsigned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg_quot <= dividend_neg ^ divisor_neg;
      neg_rem  <= dividend_neg;
    end
  end
`else
  assign dividend_mag = bus.opdata1_i;
  assign divisor_mag  = bus.opdata2_i;
  assign quot_final   = sreg_next[DATA_W-1:0];
  assign rem_final    = sreg_next[2*DATA_W-1:DATA_W];
`endif

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .sreg      (sreg),
    .divisor   (divisor_q),
    .sreg_next (sreg_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stall request and write strobe; a flush wins over everything
  always_comb begin
    state_next = state;
    busy       = (state != IDLE) || accept;
    we         = (state == END) && !bus.annul_i;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (bus.opdata2_i == '0) ? END : ON;
        end
      end
      ON: begin
        if (cnt == CNT_LAST) begin
          state_next = END;
        end
      end
      END: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (bus.annul_i) begin
      state_next = IDLE;
    end
  end

  // Datapath: load operands, iterate, and register the fixed-up result on entry to END
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      sreg      <= '0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.opdata2_i == '0) begin
              lo_q  <= DATA_W'(DIV_DBZ_QUOT);
              hi_q  <= bus.opdata1_i;
              dbz_q <= 1'b1;
            end else begin
              sreg      <= {{(DATA_W+1){1'b0}}, dividend_mag};
              divisor_q <= divisor_mag;
              cnt       <= '0;
            end
          end
        end
        ON: begin
          if (!bus.annul_i) begin
            sreg <= sreg_next;
            cnt  <= cnt + 6'd1;
            if (cnt == CNT_LAST) begin
              lo_q  <= quot_final;
              hi_q  <= rem_final;
              dbz_q <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy_o = busy;
  assign bus.we_o   = we;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  assign bus.dbz_o  = dbz_q;

endmodule
